// File: rtl/ps2_kbd_pkg.sv
// Shared constants, frame FSM state type and the set-2 to ASCII lookup.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_e;

  // Letters honour shift; digits, space, enter and backspace ignore it; 0x00 = unmapped.
  function automatic logic [7:0] sc2ascii(input logic [7:0] code, input logic shift);
    logic [7:0] c;
    case (code)
      8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
      8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
      8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
      8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
      8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
      8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
      8'h35: c = "y";  8'h1A: c = "z";
      8'h45: c = "0";  8'h16: c = "1";  8'h1E: c = "2";  8'h26: c = "3";
      8'h25: c = "4";  8'h2E: c = "5";  8'h36: c = "6";  8'h3D: c = "7";
      8'h3E: c = "8";  8'h46: c = "9";
      8'h29: c = 8'h20;
      8'h5A: c = 8'h0D;
      8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    if (shift && (c >= "a") && (c <= "z")) c = c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/ps2_kbd_if.sv
// Pin, register-block and status signals of the PS/2 keyboard controller.
interface ps2_kbd_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          ps2_clk;
  logic          ps2_data;
  logic          kbdr_full;
  logic [7:0]    ASCII;
  logic          LD_ASCII;
  logic          frame_err;
  logic          fifo_ovf;
  logic [CW-1:0] fifo_count;

  // Controller side.
  modport master (
    input  ps2_clk, ps2_data, kbdr_full,
    output ASCII, LD_ASCII, frame_err, fifo_ovf, fifo_count
  );

  // Connector / register-block side.
  modport slave (
    output ps2_clk, ps2_data, kbdr_full,
    input  ASCII, LD_ASCII, frame_err, fifo_ovf, fifo_count
  );
endinterface

// File: rtl/ps2_char_fifo.sv
// Synchronous character FIFO; pointers carry an extra MSB to tell full from empty.
module ps2_char_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  // A push while full is accepted only when a pop frees the head slot in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem[rd_ptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + ONE;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 receiver: frame FSM, make/break/shift decoder, character FIFO, KBDR load issue.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input logic       clk,
  input logic       reset,
  ps2_kbd_if.master bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q, fall;

  // Two-flop synchronizers plus a registered copy of the synced clock for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= bus.ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= bus.ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          scan_valid_q, scan_valid_d;
  logic          frame_err_q, frame_err_d;

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_err_q    <= 1'b0;
      to_cnt_q     <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_err_q    <= par_err_d;
      to_cnt_q     <= to_cnt_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Frame FSM next state: start/data/parity/stop sampling and inactivity timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_err_d    = par_err_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q == StIdle || fall) to_cnt_d = '0;
    else                           to_cnt_d = to_cnt_q + TW'(1);

    if (state_q != StIdle && !fall && to_cnt_q == TO_LAST) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        StData: begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          // Odd parity: data bits plus parity bit must hold an odd number of ones.
          if ((^shreg_q) == dat_s2_q) par_err_d = 1'b1;
          state_d = StStop;
        end
        StStop: begin
          if (dat_s2_q && !par_err_q) scan_valid_d = 1'b1;
          else                        frame_err_d  = 1'b1;
          state_d = StIdle;
        end
      endcase
    end
  end

  logic       shift_q, shift_d, brk_q, brk_d, ext_q, ext_d;
  logic       push;
  logic [7:0] char_code;

  // Decoder prefix/shift state.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
    end
  end

  // Decoder: shreg_q still holds the received byte while scan_valid_q is high.
  always_comb begin
    shift_d   = shift_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    push      = 1'b0;
    char_code = sc2ascii(shreg_q, shift_q);
    if (scan_valid_q) begin
      if (shreg_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (shreg_q == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if ((shreg_q == SC_LSHIFT || shreg_q == SC_RSHIFT) && !ext_q) shift_d = !brk_q;
        else if (!brk_q && !ext_q && char_code != 8'h00)             push    = 1'b1;
      end
    end
  end

  logic          ld, ld_q, full, empty;
  logic [7:0]    head;
  logic [CW-1:0] count;

  ps2_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (char_code),
    .pop   (ld),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The load-gap flop keeps LD_ASCII off for a cycle so kbdr_full can catch up.
  assign ld = !empty && !bus.kbdr_full && !ld_q;

  // Remember last cycle's load strobe.
  always_ff @(posedge clk) begin
    if (reset) ld_q <= 1'b0;
    else       ld_q <= ld;
  end

  assign bus.LD_ASCII   = ld;
  assign bus.ASCII      = ld ? head : 8'h00;
  assign bus.frame_err  = frame_err_q;
  assign bus.fifo_ovf   = push && full && !ld;
  assign bus.fifo_count = count;
endmodule
